// File: rtl/isp_pkg.sv
// Shared ISP definitions: mode encodings, default per-mode pipeline latencies,
// sync bundle type and the sync-align FSM state encoding.
// Imported by isp_sync_align and isp_sync_delay.
package isp_pkg;

  // Default depth of the sync delay line and per-mode pixel-path latencies.
  localparam int MAX_LAT_DEFAULT = 32;
  localparam int LAT_M0_DEFAULT  = 2;   // bypass: router regs + bayer->rgb888
  localparam int LAT_M1_DEFAULT  = 8;   // dpc + bilinear debayer
  localparam int LAT_M2_DEFAULT  = 10;  // dpc + gradient debayer
  localparam int LAT_M3_DEFAULT  = 10;  // dpc + adaptive debayer
  localparam int LAT_M4_DEFAULT  = 12;  // dpc + debayer_l + awb
  localparam int LAT_M5_DEFAULT  = 14;  // dpc + debayer_l + awb + yuv
  localparam int LAT_DEF_DEFAULT = 2;   // unsupported modes 6..15

  // Same encoding the mode router uses.
  typedef enum logic [3:0] {
    MODE_BYPASS   = 4'd0,
    MODE_BILINEAR = 4'd1,
    MODE_GRADIENT = 4'd2,
    MODE_ADAPTIVE = 4'd3,
    MODE_AWB      = 4'd4,
    MODE_YUV      = 4'd5
  } isp_mode_e;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RUN     = 2'd2,
    ST_PEND    = 2'd3
  } align_state_e;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

  // Modes above MODE_YUV have no pixel path behind them; their output is blanked.
  function automatic logic mode_supported(input logic [3:0] m);
    return (m <= 4'(MODE_YUV));
  endfunction

endpackage

// File: rtl/isp_sync_delay.sv
// Purpose: MAX_LAT-deep shift register of {vs,hs,de} with a selectable tap.
// Latency: tap_i + 1 cycles (tap 0 = input registered once); output registered.
// Backpressure: none, the line shifts every cycle regardless of state.
// Ports: clk/rst_n; sync_i raw syncs; tap_i delay select (0..MAX_LAT);
//        de_en_i gates de into the output register; sync_o delayed syncs.
module isp_sync_delay
  import isp_pkg::*;
#(
  parameter int MAX_LAT = MAX_LAT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  sync_t                        sync_i,
  input  logic [$clog2(MAX_LAT+1)-1:0] tap_i,
  input  logic                         de_en_i,
  output sync_t                        sync_o
);

  sync_t line_q [MAX_LAT];
  sync_t tap_d;
  sync_t sync_q;

  // line_q[i] holds the input from i+1 cycles ago; tap 0 takes the live input
  // so that the output register alone provides the single-cycle minimum.
  always_comb begin
    tap_d = sync_i;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (int'(tap_i) == i + 1) tap_d = line_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAT; i++) line_q[i] <= '0;
      sync_q <= '0;
    end else begin
      line_q[0] <= sync_i;
      for (int i = 1; i < MAX_LAT; i++) line_q[i] <= line_q[i-1];
      sync_q <= {tap_d.vs, tap_d.hs, tap_d.de & de_en_i};
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/isp_sync_align.sv
// Purpose: align raw video syncs to the ISP pixel path of the active mode, switching modes only at frame start.
// Latency: syncs LAT[mode_active]+1 cycles, pixel 1 cycle; de/pixel blanked while not in RUN.
// Backpressure: none, free-running video stream; mode requests wait for the next vs rising edge.
// Ports: clk, rst_n (async active-low); mode request; vs_in/hs_in/de_in raw syncs; pix_in RGB888;
//        mode_active applied mode; vs_out/hs_out/de_out aligned syncs; pix_out gated pixel;
//        switch_busy high whenever output is not in RUN.
module isp_sync_align
  import isp_pkg::*;
#(
  parameter int MAX_LAT = MAX_LAT_DEFAULT,
  parameter int LAT_M0  = LAT_M0_DEFAULT,
  parameter int LAT_M1  = LAT_M1_DEFAULT,
  parameter int LAT_M2  = LAT_M2_DEFAULT,
  parameter int LAT_M3  = LAT_M3_DEFAULT,
  parameter int LAT_M4  = LAT_M4_DEFAULT,
  parameter int LAT_M5  = LAT_M5_DEFAULT,
  parameter int LAT_DEF = LAT_DEF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mode,
  input  logic        vs_in,
  input  logic        hs_in,
  input  logic        de_in,
  input  logic [23:0] pix_in,
  output logic [3:0]  mode_active,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [23:0] pix_out,
  output logic        switch_busy
);

  localparam int TAPW = $clog2(MAX_LAT + 1);

  function automatic logic [TAPW-1:0] lat_of(input logic [3:0] m);
    case (m)
      MODE_BYPASS:   lat_of = TAPW'(LAT_M0);
      MODE_BILINEAR: lat_of = TAPW'(LAT_M1);
      MODE_GRADIENT: lat_of = TAPW'(LAT_M2);
      MODE_ADAPTIVE: lat_of = TAPW'(LAT_M3);
      MODE_AWB:      lat_of = TAPW'(LAT_M4);
      MODE_YUV:      lat_of = TAPW'(LAT_M5);
      default:       lat_of = TAPW'(LAT_DEF);
    endcase
  endfunction

  align_state_e    state_q, state_d;
  logic [3:0]      mode_active_q, mode_active_d;
  logic [TAPW-1:0] cnt_q, cnt_d;
  logic            vs_in_q;
  logic            busy_q;
  logic [23:0]     pix_q;
  logic            vs_rise;
  logic            gate_d;
  logic [TAPW-1:0] tap_sel;
  sync_t           sync_in;
  sync_t           sync_out;

  assign vs_rise = vs_in & ~vs_in_q;

  always_comb begin
    state_d       = state_q;
    mode_active_d = mode_active_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_WAIT_VS: begin
        if (vs_rise) begin
          mode_active_d = mode;
          cnt_d         = TAPW'(MAX_LAT);
          state_d       = ST_FLUSH;
        end
      end
      // Blank for exactly MAX_LAT cycles; RUN starts as the counter reaches zero.
      // Mode requests are ignored here and picked up by RUN on the next cycle.
      ST_FLUSH: begin
        cnt_d = cnt_q - TAPW'(1);
        if (cnt_q <= TAPW'(1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      // A vs_rise coinciding with a new request is not a switch point: the
      // request is first registered as pending and served at the next frame.
      ST_RUN: begin
        if (mode != mode_active_q) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (mode == mode_active_q) begin
          state_d = ST_RUN;
        end else if (vs_rise) begin
          mode_active_d = mode;
          cnt_d         = TAPW'(MAX_LAT);
          state_d       = ST_FLUSH;
        end
      end
      default: state_d = ST_WAIT_VS;
    endcase
  end

  // Output is visible only in RUN with a mode that has a real pixel path.
  // Using next-state values keeps the gate aligned with the registered outputs.
  assign gate_d = (state_d == ST_RUN) && mode_supported(mode_active_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_VS;
      mode_active_q <= '0;
      cnt_q         <= '0;
      vs_in_q       <= 1'b0;
      busy_q        <= 1'b0;
      pix_q         <= '0;
    end else begin
      state_q       <= state_d;
      mode_active_q <= mode_active_d;
      cnt_q         <= cnt_d;
      vs_in_q       <= vs_in;
      busy_q        <= (state_d != ST_RUN);
      pix_q         <= gate_d ? pix_in : 24'd0;
    end
  end

  assign sync_in = {vs_in, hs_in, de_in};
  assign tap_sel = lat_of(mode_active_q);

  isp_sync_delay #(
    .MAX_LAT (MAX_LAT)
  ) u_sync_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_i  (sync_in),
    .tap_i   (tap_sel),
    .de_en_i (gate_d),
    .sync_o  (sync_out)
  );

  assign mode_active = mode_active_q;
  assign vs_out      = sync_out.vs;
  assign hs_out      = sync_out.hs;
  assign de_out      = sync_out.de;
  assign pix_out     = pix_q;
  assign switch_busy = busy_q;

endmodule

// File: tb/tb_isp_sync_align.sv
module tb_isp_sync_align;

  localparam int MAXL = 32;
  localparam int H    = 48;   // cycles per line
  localparam int V    = 8;    // lines per frame
  localparam int PH_WAIT = 0, PH_FLUSH = 1, PH_RUN = 2, PH_PEND = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [23:0] pix_in = 24'd0;
  logic [3:0]  mode_active;
  logic        vs_out, hs_out, de_out, switch_busy;
  logic [23:0] pix_out;

  isp_sync_align dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .vs_in       (vs_in),
    .hs_in       (hs_in),
    .de_in       (de_in),
    .pix_in      (pix_in),
    .mode_active (mode_active),
    .vs_out      (vs_out),
    .hs_out      (hs_out),
    .de_out      (de_out),
    .pix_out     (pix_out),
    .switch_busy (switch_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference model: input history ring, phase, applied mode, RUN start time.
  int lat_tab [16] = '{2, 8, 10, 10, 12, 14, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
  logic [2:0] hist [64];
  int   cnum = 64;
  int   m_phase, m_ma, m_ma_prev, run_at;
  logic vs_prev2;
  int   hpos, vpos, drv_v, drv_h;

  int   busy_cnt, de_out_cnt, pix_nz_cnt;
  int   vs_in_rises, vs_out_rises, last_vs_in_rise, last_vs_dly;
  logic vs_out_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cnum);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) hist[i] = 3'b000;
    m_phase = PH_WAIT; m_ma = 0; m_ma_prev = 0; run_at = 0;
    vs_prev2 = 1'b0; vs_out_prev = 1'b0;
  endtask

  task automatic drive_next();
    logic v, h, d;
    v = (vpos == 0);
    h = (hpos < 4);
    d = (vpos >= 2) && (hpos >= 8) && (hpos < 40);
    if (v && !vs_in) begin
      vs_in_rises++;
      last_vs_in_rise = cnum;
    end
    vs_in = v; hs_in = h; de_in = d;
    pix_in = 24'($urandom);
    hist[cnum % 64] = {v, h, d};
    drv_v = vpos; drv_h = hpos;
    if (hpos == H - 1) begin
      hpos = 0;
      vpos = (vpos == V - 1) ? 0 : vpos + 1;
    end else begin
      hpos++;
    end
  endtask

  // One clock: advance the model from last cycle's inputs, compare, drive next inputs.
  task automatic cyc();
    logic [2:0] pin, e;
    logic rise, gate;
    int lat;
    @(posedge clk); #1;
    cnum++;
    pin  = hist[(cnum - 1) % 64];
    rise = pin[2] & ~vs_prev2;
    m_ma_prev = m_ma;
    case (m_phase)
      PH_WAIT: if (rise) begin
        m_ma = int'(mode); run_at = cnum + MAXL; m_phase = PH_FLUSH;
      end
      PH_FLUSH: if (cnum >= run_at) m_phase = PH_RUN;
      PH_RUN:   if (int'(mode) != m_ma) m_phase = PH_PEND;
      default: begin
        if (int'(mode) == m_ma) m_phase = PH_RUN;
        else if (rise) begin
          m_ma = int'(mode); run_at = cnum + MAXL; m_phase = PH_FLUSH;
        end
      end
    endcase
    vs_prev2 = pin[2];
    lat  = lat_tab[m_ma_prev];
    e    = hist[(cnum - 1 - lat) % 64];
    gate = (m_phase == PH_RUN) && (m_ma < 6);
    chk("vs_out", 32'(vs_out), 32'(e[2]));
    chk("hs_out", 32'(hs_out), 32'(e[1]));
    chk("de_out", 32'(de_out), 32'(e[0] & gate));
    chk("pix_out", 32'(pix_out), 32'(gate ? pix_in : 24'd0));
    chk("mode_active", 32'(mode_active), 32'(m_ma));
    chk("switch_busy", 32'(switch_busy), 32'(m_phase != PH_RUN));
    if (switch_busy) busy_cnt++;
    if (de_out) de_out_cnt++;
    if (pix_out != 24'd0) pix_nz_cnt++;
    if (vs_out && !vs_out_prev) begin
      vs_out_rises++;
      last_vs_dly = cnum - last_vs_in_rise;
    end
    vs_out_prev = vs_out;
    drive_next();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_to_driven(input int v, input int h);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!(drv_v == v && drv_h == h) && k < V * H + 2);
    chk("run_to_bound", 32'(drv_v == v && drv_h == h), 32'd1);
  endtask

  initial begin
    clear_model();
    hpos = 0; vpos = 3; drv_v = 0; drv_h = 0;
    busy_cnt = 0; de_out_cnt = 0; pix_nz_cnt = 0;
    vs_in_rises = 0; vs_out_rises = 0; last_vs_in_rise = 0; last_vs_dly = 0;
    mode = 4'd1;
    #3;
    chk("rst_vs", 32'(vs_out), 32'd0);
    chk("rst_de", 32'(de_out), 32'd0);
    chk("rst_pix", 32'(pix_out), 32'd0);
    chk("rst_mode", 32'(mode_active), 32'd0);
    chk("rst_busy", 32'(switch_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) start mid-frame with mode 1: nothing visible before the first vs
    run_to_driven(0, 0);
    chk("t1_pre_de", 32'(de_out_cnt), 32'd0);
    chk("t1_pre_pix", 32'(pix_nz_cnt), 32'd0);
    chk("t1_pre_busy", 32'(switch_busy), 32'd1);
    busy_cnt = 0;
    run(40);
    chk("t1_flush_len", 32'(busy_cnt), 32'd32);
    chk("t1_mode", 32'(mode_active), 32'd1);
    run_to_driven(1, 0);
    chk("t1_vs_dly", 32'(last_vs_dly), 32'd9);
    run_to_driven(0, 0);
    run(40);

    // 3) 1->4->1 inside one frame: blanked only for the mismatch cycles
    run_to_driven(3, 0);
    busy_cnt = 0;
    mode = 4'd4;
    run(20);
    mode = 4'd1;
    run(30);
    chk("t3_busy_len", 32'(busy_cnt), 32'd20);
    chk("t3_mode", 32'(mode_active), 32'd1);
    chk("t3_run", 32'(switch_busy), 32'd0);

    // 2) 1->5 mid-frame: deferred to the next vs, then 32-cycle flush, delay 15
    run_to_driven(5, 0);
    mode = 4'd5;
    run(5);
    chk("t2_hold_mode", 32'(mode_active), 32'd1);
    chk("t2_pend", 32'(switch_busy), 32'd1);
    run_to_driven(0, 0);
    busy_cnt = 0;
    run(40);
    chk("t2_mode", 32'(mode_active), 32'd5);
    chk("t2_flush_len", 32'(busy_cnt), 32'd32);
    run_to_driven(1, 0);
    chk("t2_vs_dly", 32'(last_vs_dly), 32'd15);

    // 4) unsupported mode 9: delay 3, permanently blank
    run_to_driven(5, 0);
    mode = 4'd9;
    run_to_driven(0, 0);
    run(40);
    chk("t4_mode", 32'(mode_active), 32'd9);
    chk("t4_run", 32'(switch_busy), 32'd0);
    de_out_cnt = 0; pix_nz_cnt = 0; vs_in_rises = 0; vs_out_rises = 0;
    run_to_driven(0, 0);
    chk("t4_vs_dly", 32'(last_vs_dly), 32'd3);
    chk("t4_de_blank", 32'(de_out_cnt), 32'd0);
    chk("t4_pix_blank", 32'(pix_nz_cnt), 32'd0);

    // 5) request on the very vs_rise cycle: switch waits one full frame
    mode = 4'd2;
    run(40);
    chk("t5_defer_mode", 32'(mode_active), 32'd9);
    chk("t5_defer_busy", 32'(switch_busy), 32'd1);
    run_to_driven(0, 0);
    run(1);
    chk("t5_mode", 32'(mode_active), 32'd2);
    run_to_driven(0, 40);
    chk("t5_vs_in_cnt", 32'(vs_in_rises), 32'd2);
    chk("t5_vs_out_cnt", 32'(vs_out_rises), 32'd2);
    chk("t5_vs_dly", 32'(last_vs_dly), 32'd11);

    // 6) async reset during FLUSH, then recovery via WAIT_VS
    mode = 4'd3;
    run_to_driven(0, 0);
    run_to_driven(0, 20);
    chk("t6_pre_vs", 32'(vs_out), 32'd1);
    chk("t6_pre_mode", 32'(mode_active), 32'd3);
    chk("t6_pre_busy", 32'(switch_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vs", 32'(vs_out), 32'd0);
    chk("t6_rst_hs", 32'(hs_out), 32'd0);
    chk("t6_rst_de", 32'(de_out), 32'd0);
    chk("t6_rst_pix", 32'(pix_out), 32'd0);
    chk("t6_rst_mode", 32'(mode_active), 32'd0);
    chk("t6_rst_busy", 32'(switch_busy), 32'd0);
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; pix_in = 24'd0;
    repeat (3) @(posedge clk);
    clear_model();
    hpos = 0; vpos = 3;
    @(negedge clk);
    rst_n = 1'b1;
    run(50);
    chk("t6_wait_mode", 32'(mode_active), 32'd0);
    chk("t6_wait_busy", 32'(switch_busy), 32'd1);
    run_to_driven(0, 0);
    run(40);
    chk("t6_rec_mode", 32'(mode_active), 32'd3);
    chk("t6_rec_run", 32'(switch_busy), 32'd0);

    // random mode requests at random times, including during flush and on vs
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) mode = 4'($urandom_range(0, 7));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
